// File: rtl/display_window_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// display_window_fetch_ctrl
//
// Prefetches pixels for a rectangular display window out of a linear,
// row-major frame buffer and plays them out in step with the VGA counters.
//
// A small FIFO sits between the frame-buffer read port and the pixel output.
// The fetch FSM keeps the FIFO topped up with one outstanding read at a time.
// Whenever the beam is inside the window, one entry is popped per clock.
//
// Parameters
//   X_POS, Y_POS   window offset (pixel clocks / lines)
//   WIDTH, HEIGHT  window size (pixels / lines)
//   DEPTH          prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous, active-low reset
//   hc, vc    horizontal / vertical counters from the timing generator
//   rd_req    frame-buffer read request (one outstanding at most)
//   rd_addr   frame-buffer read address, row-major, 0 .. WIDTH*HEIGHT-1
//   rd_ack    read accepted; rd_data valid in the same cycle
//   rd_data   pixel read from the frame buffer
//   visible   registered window flag
//   pixel     registered pixel, aligned with visible (0 outside the window)
//   underrun  sticky: a pixel was needed while the FIFO was empty
// -----------------------------------------------------------------------------
module display_window_fetch_ctrl #(
  parameter int X_POS  = 0,
  parameter int Y_POS  = 0,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 360,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  output logic        rd_req,
  output logic [17:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        visible,
  output logic [7:0]  pixel,
  output logic        underrun
);

  // Pointer width and count width (count needs one extra bit to hold DEPTH).
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Window bounds, compared unsigned at the counters' 11-bit width.
  localparam logic [10:0] X_LO = 11'(X_POS);
  localparam logic [10:0] X_HI = 11'(X_POS + WIDTH);
  localparam logic [10:0] Y_LO = 11'(Y_POS);
  localparam logic [10:0] Y_HI = 11'(Y_POS + HEIGHT);

  // Number of pixels in one window; rd_addr reaching this value ends the frame.
  localparam logic [17:0] TOTAL = 18'(WIDTH * HEIGHT);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FULL  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [17:0]     addr_reg, addr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            visible_reg;
  logic [7:0]      pixel_reg;
  logic            underrun_reg;

  logic [7:0]      mem [DEPTH];

  logic            in_window;
  logic            frame_start;
  logic            pop_valid;
  logic            push;
  logic            flush;
  logic [CW-1:0]   count_after;

  // ---------------------------------------------------------------------------
  // Beam position decode
  // ---------------------------------------------------------------------------
  assign in_window   = (hc > X_LO) && (hc <= X_HI) && (vc > Y_LO) && (vc <= Y_HI);
  assign frame_start = (hc == 11'd0) && (vc == 11'd0);

  // A pop is requested on every in-window clock; it only consumes an entry
  // when the FIFO has one. An empty pop shows up as underrun instead.
  assign pop_valid = in_window && (count_reg != '0);

  // FIFO occupancy if the read being acked this cycle is pushed, taking the
  // concurrent pop into account. Decides whether to stop requesting.
  assign count_after = count_reg + CW'(1) - CW'(pop_valid);

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state, address and FIFO push/flush strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    push       = 1'b0;
    flush      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          flush      = 1'b1;
          addr_next  = '0;
          state_next = REQ;
        end
      end

      REQ: begin
        if (frame_start && rd_ack) begin
          // The data belongs to the old frame: drop it and start over.
          flush      = 1'b1;
          addr_next  = '0;
          state_next = REQ;
        end else if (frame_start) begin
          // A read is still in flight; keep the request stable until it
          // completes, then restart.
          state_next = DRAIN;
        end else if (rd_ack) begin
          push      = 1'b1;
          addr_next = addr_reg + 18'd1;
          if (addr_next == TOTAL) begin
            state_next = DONE;
          end else if (count_after == FULL_COUNT) begin
            state_next = FULL;
          end
        end
      end

      FULL: begin
        if (frame_start) begin
          flush      = 1'b1;
          addr_next  = '0;
          state_next = REQ;
        end else if (count_reg < FULL_COUNT) begin
          // Uses the registered count, so the request resumes one clock
          // after the pop that made room.
          state_next = REQ;
        end
      end

      DRAIN: begin
        if (rd_ack) begin
          flush      = 1'b1;
          addr_next  = '0;
          state_next = REQ;
        end
      end

      DONE: begin
        if (frame_start) begin
          flush      = 1'b1;
          addr_next  = '0;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;

    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      // Pointers are PW bits wide, so they wrap modulo DEPTH by themselves.
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop_valid) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop_valid);
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      visible_reg  <= 1'b0;
      pixel_reg    <= 8'h00;
      underrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      count_reg   <= count_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      visible_reg <= in_window;
      // The head is read before any flush in the same clock takes effect.
      pixel_reg   <= pop_valid ? mem[rd_ptr_reg] : 8'h00;
      if (flush) begin
        underrun_reg <= 1'b0;
      end else if (in_window && !pop_valid) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= rd_data;
    end
  end

  // Request is a decode of the state register, so reset removes it at once.
  assign rd_req   = (state_reg == REQ) || (state_reg == DRAIN);
  assign rd_addr  = addr_reg;
  assign visible  = visible_reg;
  assign pixel    = pixel_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_display_window_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_window_fetch_ctrl
//
// Drives a small raster (16 x 10 clocks per frame) into a reduced-size window
// and compares every output after each clock against a queue-based
// reference model of the fetch and playout rules. Directed steps cover
// reset, fill, first pixel, underrun, restart, end of frame and reset
// during a request; randomized frames follow.
// -----------------------------------------------------------------------------
module tb_display_window_fetch_ctrl;

  localparam int X_POS  = 3;
  localparam int Y_POS  = 2;
  localparam int WIDTH  = 10;
  localparam int HEIGHT = 5;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int H_TOT  = 16;
  localparam int V_TOT  = 10;

  // Model phases
  localparam int M_IDLE    = 0;
  localparam int M_FETCH   = 1;
  localparam int M_WAIT    = 2;
  localparam int M_RESTART = 3;
  localparam int M_FIN     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc;
  logic [10:0] vc;
  logic        rd_req;
  logic [17:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        visible;
  logic [7:0]  pixel;
  logic        underrun;

  display_window_fetch_ctrl #(
    .X_POS (X_POS),
    .Y_POS (Y_POS),
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .hc      (hc),
    .vc      (vc),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .visible (visible),
    .pixel   (pixel),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_mode;
  logic [7:0] q[$];
  int         m_addr;
  logic       m_under;
  logic       m_vis;
  logic [7:0] m_pix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_req();
    return (m_mode == M_FETCH) || (m_mode == M_RESTART);
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    q.delete();
    m_addr  = 0;
    m_under = 1'b0;
    m_vis   = 1'b0;
    m_pix   = 8'h00;
  endtask

  task automatic model_restart();
    q.delete();
    m_addr  = 0;
    m_under = 1'b0;
    m_mode  = M_FETCH;
  endtask

  // One rising edge of behaviour, using the inputs present at that edge.
  task automatic model_edge();
    logic win;
    logic fs;
    int   pre;
    win = (int'(hc) > X_POS) && (int'(hc) <= X_POS + WIDTH) &&
          (int'(vc) > Y_POS) && (int'(vc) <= Y_POS + HEIGHT);
    fs  = (hc == 11'd0) && (vc == 11'd0);
    pre = q.size();

    m_vis = win;
    m_pix = 8'h00;
    if (win) begin
      if (q.size() > 0) m_pix = q.pop_front();
      else              m_under = 1'b1;
    end

    case (m_mode)
      M_IDLE:  if (fs) model_restart();
      M_FETCH: begin
        if (fs && rd_ack) model_restart();
        else if (fs) m_mode = M_RESTART;
        else if (rd_ack) begin
          $display("read   addr=%0d data=%02h", m_addr, rd_data);
          q.push_back(rd_data);
          m_addr++;
          if (m_addr == TOTAL)        m_mode = M_FIN;
          else if (q.size() == DEPTH) m_mode = M_WAIT;
        end
      end
      M_WAIT: begin
        if (fs) model_restart();
        else if (pre < DEPTH) m_mode = M_FETCH;
      end
      M_RESTART: if (rd_ack) begin
        $display("discard addr=%0d data=%02h", m_addr, rd_data);
        model_restart();
      end
      M_FIN:   if (fs) model_restart();
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("visible",  32'(visible),  32'(m_vis));
    chk("pixel",    32'(pixel),    32'(m_pix));
    chk("rd_req",   32'(rd_req),   32'(m_req()));
    chk("rd_addr",  32'(rd_addr),  32'(m_addr));
    chk("underrun", 32'(underrun), 32'(m_under));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic advance_raster();
    if (int'(hc) == H_TOT - 1) begin
      hc = 11'd0;
      vc = (int'(vc) == V_TOT - 1) ? 11'd0 : vc + 11'd1;
    end else begin
      hc = hc + 11'd1;
    end
  endtask

  initial begin
    int rs_addr;
    int last_addr;
    int p;

    // ---- reset --------------------------------------------------------------
    hc = 11'd14; vc = 11'd0; rd_ack = 1'b0; rd_data = 8'h00;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #1;
    check_all();
    step();
    rst = 1'b1;
    step();

    // ---- fill: fs, ack every cycle, no pops ---------------------------------
    hc = 11'd0; vc = 11'd0;
    step();
    hc = 11'd14; vc = 11'd0;
    for (int i = 0; i < 4; i++) begin
      rd_ack  = 1'b1;
      rd_data = (i == 0) ? 8'hA5 : 8'($urandom);
      step();
    end
    rd_ack = 1'b0;
    chk("fill_addr", 32'(rd_addr), 32'd4);
    chk("fill_req",  32'(rd_req),  32'd0);

    // ---- first pixel -----------------------------------------------------
    hc = 11'(X_POS + 1); vc = 11'(Y_POS + 1);
    step();
    chk("first_vis", 32'(visible), 32'd1);
    chk("first_pix", 32'(pixel),   32'hA5);
    chk("first_req_low", 32'(rd_req), 32'd0);
    hc = 11'd14; vc = 11'd0;
    step();
    chk("first_req_back", 32'(rd_req), 32'd1);

    // ---- underrun: no acks while the window runs ---------------------------
    rd_ack = 1'b0;
    vc = 11'(Y_POS + 1);
    for (int i = 0; i < 6; i++) begin
      hc = 11'(X_POS + 1 + i);
      step();
    end
    chk("under_vis",  32'(visible),  32'd1);
    chk("under_pix",  32'(pixel),    32'h00);
    chk("under_flag", 32'(underrun), 32'd1);
    hc = 11'd14; vc = 11'd0;
    step();
    step();
    chk("under_sticky", 32'(underrun), 32'd1);

    // ---- restart with a request outstanding --------------------------------
    for (int i = 0; i < 20; i++) begin
      hc = 11'(X_POS + 1 + (i % WIDTH)); vc = 11'(Y_POS + 1);
      rd_ack  = m_req();
      rd_data = 8'($urandom);
      step();
    end
    rd_ack  = 1'b0;
    rs_addr = m_addr;
    chk("rs_req_before", 32'(rd_req), 32'd1);
    hc = 11'd0; vc = 11'd0;
    step();
    chk("rs_addr_hold", 32'(rd_addr), 32'(rs_addr));
    chk("rs_req_hold",  32'(rd_req),  32'd1);
    hc = 11'd14; vc = 11'd0;
    step();
    step();
    rd_ack = 1'b1; rd_data = 8'h3C;
    step();
    rd_ack = 1'b0;
    chk("rs_addr_zero", 32'(rd_addr),  32'd0);
    chk("rs_under_clr", 32'(underrun), 32'd0);
    chk("rs_req",       32'(rd_req),   32'd1);
    hc = 11'(X_POS + 1); vc = 11'(Y_POS + 1);
    step();
    chk("rs_empty_pix", 32'(pixel),    32'h00);
    chk("rs_empty_und", 32'(underrun), 32'd1);

    // ---- end of frame: full frame with ack every requested cycle -------------
    hc = 11'd0; vc = 11'd0;
    last_addr = -1;
    for (int n = 0; n < H_TOT * V_TOT; n++) begin
      rd_ack  = m_req();
      rd_data = 8'($urandom);
      step();
      if (rd_req === 1'b1 && int'(rd_addr) > last_addr) last_addr = int'(rd_addr);
      advance_raster();
    end
    rd_ack = 1'b0;
    chk("eof_last_addr", 32'(last_addr), 32'(TOTAL - 1));
    chk("eof_addr",      32'(rd_addr),   32'(TOTAL));
    chk("eof_req",       32'(rd_req),    32'd0);
    chk("eof_underrun",  32'(underrun),  32'd0);

    // ---- reset in the middle of a request -----------------------------------
    step();                        // hc = vc = 0 here: frame start
    hc = 11'd14; vc = 11'd0;
    for (int i = 0; i < 3; i++) begin
      rd_ack = 1'b1; rd_data = 8'($urandom);
      step();
    end
    rd_ack = 1'b0;
    step();
    chk("mr_req_before", 32'(rd_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mr_req",      32'(rd_req),   32'd0);
    chk("mr_addr",     32'(rd_addr),  32'd0);
    chk("mr_visible",  32'(visible),  32'd0);
    chk("mr_pixel",    32'(pixel),    32'h00);
    chk("mr_underrun", 32'(underrun), 32'd0);
    rd_ack = 1'b1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_data = 8'($urandom);
      step();
    end
    rd_ack = 1'b0;
    chk("late_ack_req",  32'(rd_req),  32'd0);
    chk("late_ack_addr", 32'(rd_addr), 32'd0);

    // ---- randomized frames -------------------------------------------------
    hc = 11'd0; vc = 11'd0;
    for (int f = 0; f < 6; f++) begin
      p = int'($urandom_range(40, 100));
      for (int n = 0; n < H_TOT * V_TOT; n++) begin
        if ($urandom_range(0, 199) == 0) begin
          hc = 11'd0; vc = 11'd0;
        end
        if (m_req()) rd_ack = (int'($urandom_range(1, 100)) <= p);
        else         rd_ack = ($urandom_range(0, 7) == 0);
        rd_data = 8'($urandom);
        step();
        advance_raster();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_window_fetch_ctrl.md
DISPLAY_WINDOW_FETCH_CTRL -- requirements
Module: display_window_fetch_ctrl

Interface
REQ-001 Parameter X_POS, default 0: horizontal window offset in pixel clocks.
REQ-002 Parameter Y_POS, default 0: vertical window offset in lines.
REQ-003 Parameter WIDTH, default 480: window width in pixels.
REQ-004 Parameter HEIGHT, default 360: window height in lines.
REQ-005 Parameter DEPTH, default 4: prefetch FIFO entries (power of 2, at least 2).
REQ-006 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Ports hc and vc, input, 11 each: current horizontal and vertical counters from the VGA timing generator.
REQ-009 Port rd_req, output, 1: frame-buffer read request.
REQ-010 Port rd_addr, output, 18: frame-buffer read address, linear and row-major.
REQ-011 Port rd_ack, input, 1: read accepted; rd_data is valid in the same cycle.
REQ-012 Port rd_data, input, 8: read pixel value.
REQ-013 Port visible, output, 1: registered window flag.
REQ-014 Port pixel, output, 8: registered pixel value, aligned with visible.
REQ-015 Port underrun, output, 1: sticky flag, set when the FIFO is empty at a pixel pop.

Function
REQ-016 The window condition SHALL be X_POS < hc <= X_POS+WIDTH and Y_POS < vc <= Y_POS+HEIGHT, both compared unsigned at 11 bits.
REQ-017 The visible output SHALL equal the window condition delayed by exactly 1 clk.
REQ-018 When the window condition is true, the block SHALL pop the FIFO and register the head entry into pixel in the same edge as visible; when the condition is false, pixel SHALL be 8'h00.
REQ-019 A pop while the FIFO is empty SHALL produce pixel = 8'h00 and set underrun; the FIFO count SHALL stay at 0.
REQ-020 Frame start (fs) SHALL be hc==0 and vc==0 sampled at a clock edge.
REQ-021 The FSM SHALL have the states IDLE, REQ, FULL, DRAIN and DONE.
REQ-022 IDLE -> REQ on fs: the FIFO is flushed, rd_addr = 0 and underrun is cleared.
REQ-023 In REQ, rd_req = 1 and rd_addr SHALL stay stable until rd_ack.
REQ-024 On rd_ack in REQ, rd_data is pushed and rd_addr increments; the next state is then chosen in this order of priority:
- DONE if the new address equals WIDTH*HEIGHT;
- else FULL if the FIFO count after push and pop equals DEPTH;
- else REQ.
REQ-025 In FULL, rd_req = 0; FULL -> REQ in the cycle after the count drops below DEPTH.
REQ-026 In DONE, rd_req = 0 until the next fs.
REQ-027 At most one request SHALL be outstanding; rd_req SHALL NOT be asserted while the count equals DEPTH.
REQ-028 A push and a pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-029 fs in FULL or DONE SHALL act as IDLE -> REQ, as in REQ-022.
REQ-030 fs in REQ while rd_ack = 0 SHALL move to DRAIN:
- rd_req and rd_addr are held until rd_ack;
- the acked data is discarded;
- the FIFO is flushed, underrun is cleared, and rd_addr goes to 0 on the ack edge;
- the next state is REQ.
REQ-031 fs in REQ coincident with rd_ack SHALL discard that data and behave as REQ-022.
REQ-032 rd_addr SHALL never exceed WIDTH*HEIGHT-1 while rd_req = 1.
REQ-033 The FIFO count SHALL be ceil(log2(DEPTH))+1 bits wide, and its pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 While rst = 0, the block SHALL hold:
- state = IDLE;
- rd_req, rd_addr, visible, pixel and underrun = 0;
- FIFO count and pointers = 0.
REQ-035 Reset SHALL take effect asynchronously; release SHALL be sampled on the next clk edge.
REQ-036 Reset asserted mid-request SHALL drop rd_req immediately, and any later rd_ack while in IDLE SHALL be ignored.

Verification
REQ-037 Scenario, fill: defaults, fs, rd_ack every cycle, no pop -> addresses 0..3 are acked, state is FULL, rd_req = 0, count = 4.
REQ-038 Scenario, first pixel: window entered at hc = 1, vc = 1 with FIFO holding 8'hA5 -> the next edge gives visible = 1 and pixel = 8'hA5; the count drops by 1 and rd_req reasserts one cycle later.
REQ-039 Scenario, end of frame: full frame streamed with ack every cycle -> the last rd_addr is 172799 and the state is DONE; underrun = 0 when the source keeps up.
REQ-040 Scenario, underrun: rd_ack held at 0 while the window is active -> pixel = 8'h00, visible = 1, underrun = 1 until the next fs.
REQ-041 Scenario, restart: fs injected while a request is outstanding at rd_addr = 1000, then rd_ack 3 cycles later -> the data is discarded, the FIFO is empty, the next rd_addr = 0 and underrun = 0.
REQ-042 Scenario, reset mid-request: rst pulsed low while rd_req = 1 -> all outputs are 0 at once, the state is IDLE, and a late rd_ack has no effect.
